// File: rtl/step_sequencer.sv
// step_sequencer: plays a small pattern RAM of (frequency, gate) steps at a
// programmable tempo and presents the current pitch/gate to the synth datapath.
// The pattern is written one entry per cycle through a simple write port.
module step_sequencer #(
  parameter  int STEPS   = 8,
  parameter  int FREQ_W  = 24,
  parameter  int TEMPO_W = 16,
  localparam int AW      = $clog2(STEPS)
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               wr_en,
  input  logic [AW-1:0]      wr_addr,
  input  logic [FREQ_W-1:0]  wr_freq,
  input  logic               wr_gate,
  input  logic               run,
  input  logic               loop,
  input  logic [AW-1:0]      last_step,
  input  logic [TEMPO_W-1:0] tempo_div,
  input  logic [TEMPO_W-1:0] gate_len,
  output logic [FREQ_W-1:0]  freq_out,
  output logic               gate_out,
  output logic [AW-1:0]      step_idx,
  output logic               step_pulse,
  output logic               done,
  output logic               playing
);

  typedef enum logic {IDLE = 1'b0, PLAY = 1'b1} state_e;

  typedef struct packed {
    logic [FREQ_W-1:0] freq;
    logic              gate;
  } entry_t;

  entry_t mem_q [STEPS];

  state_e             state_q, state_d;
  logic [TEMPO_W-1:0] cnt_q, cnt_d;
  logic [AW-1:0]      idx_q, idx_d;
  logic [FREQ_W-1:0]  freq_q, freq_d;
  logic               gate_q, gate_d;
  logic               pulse_q, pulse_d;
  logic               done_q, done_d;

  logic               fetch;
  logic [AW-1:0]      fetch_idx;
  logic               step_end;
  logic               last_hit;
  logic [TEMPO_W:0]   cnt_inc;

  assign step_end = (cnt_q == tempo_div);
  assign last_hit = (idx_q >= last_step);
  // One extra bit so the gate-length compare cannot wrap at the top of the range.
  assign cnt_inc  = {1'b0, cnt_q} + (TEMPO_W+1)'(1);

  // Pattern RAM write port; a fetch on the same edge sees the old entry.
  // NOTE: the RAM is deliberately left out of reset so it maps onto plain
  // memory; entries are undefined until the host writes them.
  always_ff @(posedge clk) begin
    if (wr_en) mem_q[wr_addr] <= '{freq: wr_freq, gate: wr_gate};
  end

  // Next-state logic: start/stop, tempo count, gate timing and step fetch.
  always_comb begin
    // NOTE: every signal written here gets a default first, otherwise paths
    // that skip an assignment would infer latches.
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    freq_d    = freq_q;
    gate_d    = gate_q;
    pulse_d   = 1'b0;
    done_d    = 1'b0;
    fetch     = 1'b0;
    fetch_idx = '0;

    case (state_q)
      IDLE: begin
        if (run) begin
          state_d   = PLAY;
          fetch     = 1'b1;
          fetch_idx = '0;
        end
      end
      PLAY: begin
        if (!run) begin
          // Stop without a done strobe; pitch holds so a release tail keeps its note.
          state_d = IDLE;
          gate_d  = 1'b0;
        end else if (step_end) begin
          if (last_hit && !loop) begin
            state_d = IDLE;
            gate_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            fetch     = 1'b1;
            fetch_idx = last_hit ? '0 : idx_q + AW'(1);
          end
        end else begin
          cnt_d  = cnt_q + TEMPO_W'(1);
          gate_d = gate_q && (cnt_inc < {1'b0, gate_len});
        end
      end
      default: state_d = IDLE;
    endcase

    // Latching the new step directly keeps gate high across note-to-note
    // boundaries when the gate outlasts the step (legato).
    if (fetch) begin
      idx_d   = fetch_idx;
      cnt_d   = '0;
      pulse_d = 1'b1;
      freq_d  = mem_q[fetch_idx].freq;
      gate_d  = mem_q[fetch_idx].gate && (gate_len != '0);
    end
  end

  // Sequencer state and registered outputs with synchronous reset.
  always_ff @(posedge clk) begin
    // NOTE: state flops use non-blocking assignments so every flop samples
    // pre-edge values regardless of statement order.
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      idx_q   <= '0;
      freq_q  <= '0;
      gate_q  <= 1'b0;
      pulse_q <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      idx_q   <= idx_d;
      freq_q  <= freq_d;
      gate_q  <= gate_d;
      pulse_q <= pulse_d;
      done_q  <= done_d;
    end
  end

  assign freq_out   = freq_q;
  assign gate_out   = gate_q;
  assign step_idx   = idx_q;
  assign step_pulse = pulse_q;
  assign done       = done_q;
  assign playing    = (state_q == PLAY);

endmodule

// File: tb/tb_step_sequencer.sv
// Self-checking bench for step_sequencer: directed scenarios with fixed
// expectations, then randomized play checked every cycle against a
// step-timeline reference model.
module tb_step_sequencer;

  localparam int STEPS = 8;
  localparam int AW    = 3;

  logic              clk = 1'b0;
  logic              rst;
  logic              wr_en;
  logic [AW-1:0]     wr_addr;
  logic [23:0]       wr_freq;
  logic              wr_gate;
  logic              run;
  logic              loop;
  logic [AW-1:0]     last_step;
  logic [15:0]       tempo_div;
  logic [15:0]       gate_len;
  logic [23:0]       freq_out;
  logic              gate_out;
  logic [AW-1:0]     step_idx;
  logic              step_pulse;
  logic              done;
  logic              playing;

  int n_checks = 0;
  int n_fail   = 0;

  step_sequencer #(.STEPS(STEPS), .FREQ_W(24), .TEMPO_W(16)) dut (
    .clk(clk), .rst(rst),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_freq(wr_freq), .wr_gate(wr_gate),
    .run(run), .loop(loop), .last_step(last_step),
    .tempo_div(tempo_div), .gate_len(gate_len),
    .freq_out(freq_out), .gate_out(gate_out), .step_idx(step_idx),
    .step_pulse(step_pulse), .done(done), .playing(playing)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got=0x%0h expected=0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Reference model: which step is sounding and how long it has sounded.
  bit          m_play, m_note, m_pulse, m_done;
  int          m_idx, m_t, m_glen;
  logic [23:0] m_freq;
  logic [23:0] mf [STEPS];
  bit          mg [STEPS];

  task automatic start_step(input int i);
    m_play  = 1;
    m_idx   = i;
    m_t     = 0;
    m_freq  = mf[i];
    m_note  = mg[i];
    m_glen  = gate_len;
    m_pulse = 1;
  endtask

  always @(posedge clk) begin
    if (rst) begin
      m_play = 0; m_note = 0; m_pulse = 0; m_done = 0;
      m_idx = 0; m_t = 0; m_freq = '0;
    end else begin
      m_pulse = 0;
      m_done  = 0;
      if (!m_play) begin
        if (run) start_step(0);
      end else if (!run) begin
        m_play = 0;
        m_note = 0;
      end else if (m_t == int'(tempo_div)) begin
        if (m_idx >= int'(last_step)) begin
          if (loop) start_step(0);
          else begin
            m_play = 0;
            m_note = 0;
            m_done = 1;
          end
        end else begin
          start_step(m_idx + 1);
        end
      end else begin
        m_t++;
      end
    end
    // Writes land after this edge's fetch, so a same-edge fetch sees old data.
    if (wr_en) begin
      mf[wr_addr] = wr_freq;
      mg[wr_addr] = wr_gate;
    end
  end

  // Continuous comparison against the model, away from the active edge.
  always @(negedge clk) begin
    check("m_freq",    32'(freq_out),   32'(m_freq));
    check("m_gate",    32'(gate_out),   32'(m_play && m_note && (m_t < m_glen)));
    check("m_idx",     32'(step_idx),   32'(m_idx));
    check("m_pulse",   32'(step_pulse), 32'(m_pulse));
    check("m_done",    32'(done),       32'(m_done));
    check("m_playing", 32'(playing),    32'(m_play));
  end

  task automatic write_entry(input int a, input logic [23:0] f, input bit g);
    wr_en   = 1'b1;
    wr_addr = AW'(a);
    wr_freq = f;
    wr_gate = g;
    step(1);
    wr_en   = 1'b0;
  endtask

  initial begin
    rst = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_freq = '0; wr_gate = 1'b0;
    run = 1'b0; loop = 1'b1; last_step = 3'd3; tempo_div = 16'd9; gate_len = 16'd4;
    step(2);
    check("rst_freq", 32'(freq_out), 32'h0);
    check("rst_play", 32'(playing),  32'h0);
    check("rst_gate", 32'(gate_out), 32'h0);
    rst = 1'b0;

    write_entry(0, 24'h001000, 1'b1);
    write_entry(1, 24'h002000, 1'b0);
    write_entry(2, 24'h003000, 1'b1);
    write_entry(3, 24'h004000, 1'b1);
    for (int i = 4; i < STEPS; i++) write_entry(i, 24'($urandom), 1'($urandom));

    // Looping pattern, gate 4 of 10 clocks
    run = 1'b1;
    step(1);
    check("t1_idx0",   32'(step_idx),   32'd0);
    check("t1_pulse0", 32'(step_pulse), 32'd1);
    check("t1_freq0",  32'(freq_out),   32'h001000);
    check("t1_gate0",  32'(gate_out),   32'd1);
    step(3);
    check("t1_gate_hi", 32'(gate_out), 32'd1);
    step(1);
    check("t1_gate_lo", 32'(gate_out), 32'd0);
    step(6);
    check("t1_idx1",   32'(step_idx),   32'd1);
    check("t1_pulse1", 32'(step_pulse), 32'd1);
    check("t1_rest",   32'(gate_out),   32'd0);
    check("t1_freq1",  32'(freq_out),   32'h002000);
    step(1);
    check("t1_pulse_off", 32'(step_pulse), 32'd0);
    step(29);
    check("t1_wrap_idx",  32'(step_idx),   32'd0);
    check("t1_wrap_freq", 32'(freq_out),   32'h001000);

    // One-shot end
    loop = 1'b0;
    step(40);
    check("t2_done",    32'(done),       32'd1);
    check("t2_playing", 32'(playing),    32'd0);
    check("t2_gate",    32'(gate_out),   32'd0);
    check("t2_freq",    32'(freq_out),   32'h004000);
    check("t2_pulse",   32'(step_pulse), 32'd0);
    run = 1'b0;
    step(1);
    check("t2_done_off", 32'(done), 32'd0);

    // Same-edge write is not seen by the fetch; stop and restart mid step
    loop = 1'b1;
    run  = 1'b1;
    step(10);
    wr_en = 1'b1; wr_addr = 3'd1; wr_freq = 24'h0ABCDE; wr_gate = 1'b1;
    step(1);
    wr_en = 1'b0;
    check("t5_old_freq", 32'(freq_out), 32'h002000);
    check("t5_idx1",     32'(step_idx), 32'd1);
    step(3);
    run = 1'b0;
    step(1);
    check("t4_stop_gate", 32'(gate_out), 32'd0);
    check("t4_stop_play", 32'(playing),  32'd0);
    check("t4_no_done",   32'(done),     32'd0);
    run = 1'b1;
    step(1);
    check("t4_restart_idx",   32'(step_idx),   32'd0);
    check("t4_restart_pulse", 32'(step_pulse), 32'd1);
    step(10);
    check("t5_new_freq", 32'(freq_out), 32'h0ABCDE);

    // Legato across notes 2 and 3
    run = 1'b0;
    step(1);
    gate_len = 16'd20;
    run = 1'b1;
    step(21);
    check("t3_idx2",  32'(step_idx), 32'd2);
    check("t3_gate2", 32'(gate_out), 32'd1);
    step(9);
    check("t3_gate2_end", 32'(gate_out), 32'd1);
    step(1);
    check("t3_idx3",   32'(step_idx), 32'd3);
    check("t3_legato", 32'(gate_out), 32'd1);
    step(9);
    check("t3_gate3_end", 32'(gate_out), 32'd1);

    // Reset during play, run held high
    rst = 1'b1;
    step(1);
    check("t6_freq",  32'(freq_out),   32'h0);
    check("t6_gate",  32'(gate_out),   32'd0);
    check("t6_pulse", 32'(step_pulse), 32'd0);
    check("t6_play",  32'(playing),    32'd0);
    rst = 1'b0;
    step(1);
    check("t6_restart_play", 32'(playing),    32'd1);
    check("t6_restart_idx",  32'(step_idx),   32'd0);
    check("t6_restart_pls",  32'(step_pulse), 32'd1);

    // Randomized episodes; timing parameters only change while stopped
    for (int ep = 0; ep < 40; ep++) begin
      run       = 1'b0;
      tempo_div = 16'($urandom_range(0, 6));
      gate_len  = 16'($urandom_range(0, 9));
      loop      = 1'($urandom);
      last_step = AW'($urandom);
      step(1);
      for (int c = 0; c < 60; c++) begin
        run   = ($urandom_range(0, 39) != 0);
        rst   = ($urandom_range(0, 149) == 0);
        wr_en = ($urandom_range(0, 2) == 0);
        wr_addr = AW'($urandom);
        wr_freq = 24'($urandom);
        wr_gate = 1'($urandom);
        if ($urandom_range(0, 19) == 0) last_step = AW'($urandom);
        step(1);
      end
      rst   = 1'b0;
      wr_en = 1'b0;
    end

    step(2);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
